// File: rtl/serial_alu_n.sv
// Multi-cycle ALU: WIDTH-bit operands are processed LSB-first, BPC bits per cycle,
// through a slice datapath with a registered carry and a start/busy/done handshake.
module serial_alu_n #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Carry-in of the first slice: SUB, INC and NEG add an implicit +1.
    function automatic logic seed_carry(input logic [3:0] op);
        seed_carry = (op == 4'h9) || (op == 4'hA) || (op == 4'hE);
    endfunction

    // One BPC-bit slice of the selected operation; returns {carry_out, bits}.
    function automatic logic [BPC:0] slice_op(input logic [3:0] op, input logic [BPC-1:0] x,
                                              input logic [BPC-1:0] y, input logic cin);
        logic [BPC:0] r;
        r = '0;
        case (op)
            4'h0:    r = {1'b0, x & y};
            4'h1:    r = {1'b0, x | y};
            4'h2:    r = {1'b0, x ^ y};
            4'h3:    r = {1'b0, ~(x & y)};
            4'h4:    r = {1'b0, ~(x | y)};
            4'h5:    r = {1'b0, ~(x ^ y)};
            4'h6:    r = {1'b0, ~x};
            4'h7:    r = {1'b0, x};
            4'h8:    r = {1'b0, x} + {1'b0, y} + {{BPC{1'b0}}, cin};
            4'h9:    r = {1'b0, x} + {1'b0, ~y} + {{BPC{1'b0}}, cin};
            4'hA:    r = {1'b0, x} + {{BPC{1'b0}}, cin};
            4'hB:    r = {1'b0, x} + {1'b0, {BPC{1'b1}}} + {{BPC{1'b0}}, cin};
            // SHL: incoming bit is the previous slice's top bit, outgoing is this slice's top bit
            4'hC:    r = {x, cin};
            4'hD:    r = {1'b0, y};
            4'hE:    r = {1'b0, ~x} + {{BPC{1'b0}}, cin};
            4'hF:    r = '0;
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, result_q, result_d;
    logic [3:0]       sel_q, sel_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cin_q, cin_d;
    logic             busy_q, busy_d, done_q, done_d, carry_q, carry_d, zero_q, zero_d;
    logic [BPC:0]     slice_s;
    logic [WIDTH-1:0] res_sh_s;

    // Next-state, slice datapath and output-register computation.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        cin_d    = cin_q;
        res_d    = res_q;
        busy_d   = busy_q;
        done_d   = done_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        slice_s  = slice_op(sel_q, a_q[BPC-1:0], b_q[BPC-1:0], cin_q);
        res_sh_s = res_q >> BPC;
        res_sh_s[WIDTH-1 -: BPC] = slice_s[BPC-1:0];
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sel_d   = sel;
                    cnt_d   = '0;
                    cin_d   = seed_carry(sel);
                    res_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // Operands shift right so the current slice is always in the low bits.
                a_d   = a_q >> BPC;
                b_d   = b_q >> BPC;
                cin_d = slice_s[BPC];
                res_d = res_sh_s;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = res_sh_s;
                    carry_d  = slice_s[BPC];
                    zero_d   = (res_sh_s == '0);
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= 4'h0;
            cnt_q    <= '0;
            cin_q    <= 1'b0;
            res_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            cin_q    <= cin_d;
            res_q    <= res_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;

endmodule
